// File: rtl/muldiv_seq.sv
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle RV32M multiply/divide sequencer (shift-add / restoring).
//               Divider datapath and its corner-case fast path are built only
//               when MULDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] c_last = CW'(XLEN - 1);

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [2:0]          r_op;
    logic                r_neg;
    logic                r_ill;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;      // mul: {hi, multiplier}; div: {rem, dividend}
    logic [XLEN-1:0]     r_mcand;    // multiplicand or divisor
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_a_sgn, w_b_sgn, w_neg_in;
    logic [XLEN-1:0]     w_a_abs, w_b_abs;
    logic                w_fast, w_fast_ill;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_acc_next, w_fin;
    logic [XLEN-1:0]     w_res;

    assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);

    // Operand conditioning: magnitudes plus a single result-sign flag
    assign w_a_sgn  = a[XLEN-1] && (op == c_op_mulh || op == c_op_mulhsu ||
                                    op == c_op_div  || op == c_op_rem);
    assign w_b_sgn  = b[XLEN-1] && (op == c_op_mulh || op == c_op_div || op == c_op_rem);
    assign w_a_abs  = w_a_sgn ? -a : a;
    assign w_b_abs  = w_b_sgn ? -b : b;
    assign w_neg_in = (op == c_op_rem) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);

`ifdef MULDIV_DIV_EN
    logic          w_div_zero, w_div_ovf;
    logic [XLEN:0] w_trial;

    assign w_div_zero = (b == '0);
    assign w_div_ovf  = (op == c_op_div || op == c_op_rem) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_fast     = op[2] && (w_div_zero || w_div_ovf);
    assign w_fast_ill = 1'b0;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign w_fast_res = w_div_zero ? (op[1] ? a : '1)
                                   : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};
`else
    assign w_fast     = op[2];
    assign w_fast_ill = 1'b1;
    assign w_fast_res = '0;
`endif

    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand};

    always_comb begin
        w_acc_next = r_r_acc_default();
`ifdef MULDIV_DIV_EN
        if (r_op[2]) begin
            if (!w_trial[XLEN])
                w_acc_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
        end else
`endif
        if (r_acc[0])
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
        else
            w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
    end

    function automatic logic [2*XLEN-1:0] r_r_acc_default();
        return '0;
    endfunction

    assign w_fin = r_neg ? -w_acc_next : w_acc_next;

    always_comb begin
        w_res = w_fin[2*XLEN-1:XLEN];
        case (r_op)
            c_op_mul: w_res = w_acc_next[XLEN-1:0];
`ifdef MULDIV_DIV_EN
            c_op_div, c_op_divu:
                w_res = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
            c_op_rem, c_op_remu:
                w_res = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (r_state == S_CALC)
            w_state_next = (r_cnt == c_last) ? S_DONE : S_CALC;
        if (w_accept)
            w_state_next = w_fast ? S_DONE : S_CALC;
        if (flush)
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_ill    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_neg   <= w_neg_in;
            r_cnt   <= '0;
            r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_a_abs : w_b_abs)};
            r_mcand <= op[2] ? w_b_abs : w_a_abs;
            if (w_fast) begin
                r_result <= w_fast_res;
                r_ill    <= w_fast_ill;
            end
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == c_last) begin
                r_result <= w_res;
                r_ill    <= 1'b0;
            end
        end
    end

    always_comb begin
        busy    = (r_state == S_CALC);
        done    = (r_state == S_DONE);
        illegal = (r_state == S_DONE) && r_ill;
    end

    assign result = r_result;

endmodule

`default_nettype wire
